controlador_entrada: RTL and testbench
======================================

# controlador_entrada

User-side responder for the processor's input instruction. When the I/O module raises a request and halts the core, this block waits for the operator to press the Set key, debounces it, and latches the 13 switch bits. It then returns the value as a 32-bit word through a four-phase valid/request handshake. It sits between the board's switches and keys and the I/O module's input data path, on the divided system clock.

## Interface
- DEBOUNCE_CYCLES, 4, number of synchronized samples the Set key must hold stable; legal range 1–255
- Clock  in  1  system clock (divided clock; all logic on the rising edge)
- Reset  in  1  asynchronous, active-low; clears all state immediately
- Switches  in  13  raw switch value, sampled only at the latch edge
- Set  in  1  raw push key, active-low (0 = pressed), asynchronous to Clock
- Req  in  1  input request from the I/O module; high while the core is halted on an input instruction
- Data  out  32  latched switch word, extended per Configuration; reset 0
- Valid  out  1  Data is valid and held stable; reset 0
- Waiting  out  1  LED: a request is pending and a key press is expected; reset 0
- Contagem  out  8  count of completed inputs, wraps 255→0; reset 0

## Operation
- Set passes through a 2-flop synchronizer. Both flops reset to 1 (released). pressed = ~sync2.
- FSM states, reset state IDLE:
  - IDLE: Valid=0, Waiting=0. If Req=1, go to WAIT_PRESS.
  - WAIT_PRESS: Waiting=1.
    - If Req=0, go to IDLE.
    - Else if pressed, clear cnt and go to DEB.
  - DEB: Waiting=1.
    - If Req=0, go to IDLE.
    - Else if !pressed, go to WAIT_PRESS.
    - Else if cnt==DEBOUNCE_CYCLES-1: latch Data from Switches, increment Contagem, go to DELIVER.
    - Else increment cnt.
  - DELIVER: Valid=1, Waiting=0, Data held.
    - If Req=0, clear cnt and go to WAIT_RELEASE.
  - WAIT_RELEASE: Valid=0.
    - pressed clears cnt.
    - If !pressed and cnt==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else if !pressed, increment cnt.
    - Req is ignored in this state. A new request waits in WAIT_RELEASE, then passes through IDLE.
- A single key press satisfies at most one request. A key held across two requests is not accepted again until it is released and pressed anew.
- Data keeps its last value in all states except reset. Contagem updates only on entry to DELIVER.
- Switches changing while in DELIVER has no effect on Data.
- cnt is 8 bits wide and is only compared against DEBOUNCE_CYCLES-1, so it never wraps.
- Reset asserted in any state returns everything to the reset values asynchronously, including the synchronizer. The pending request is re-served from IDLE once Reset releases while Req=1.

## Timing
- Edge numbering: edge 0 is the first edge at which sync1 samples Set=0. This requires Req=1 and state WAIT_PRESS.
- Edge 1: pressed=1. Edge 2: state=DEB. Edge DEBOUNCE_CYCLES+2: state=DELIVER, Valid=1, Data latched from Switches at that edge.
- IDLE→WAIT_PRESS takes 1 edge after Req rises.
- Valid falls on the first edge where Req=0 is sampled in DELIVER, a latency of 1.
- Release path: from the first edge at which sync1 samples Set=1, IDLE is reached at edge DEBOUNCE_CYCLES+1, provided Req is already low.
- A press glitch shorter than DEBOUNCE_CYCLES+1 synchronized samples never produces Valid.
- Req dropping in the same cycle that DEB would complete: the abort wins. Go to IDLE, do not latch, do not count.

## Configuration
- SIGNED_INPUT_EN defined: Data = {19{Switches[12]}, Switches}, so switch inputs are two's complement.
- SIGNED_INPUT_EN undefined: Data = {19'b0, Switches}.
- Handshake, FSM, and timing are identical in both builds.

## Test plan
- Reset mid-DEB: Reset=0 → Valid=0, Waiting=0, Data=0, Contagem=0 immediately, before any Clock edge.
- Normal input, DEBOUNCE_CYCLES=4, unsigned build: Req=1, Switches=13'h0ABC, Set low → Valid=1 at edge 6, Data=32'h00000ABC, Contagem=1. Drop Req → Valid=0 next edge.
- Signed build: Switches=13'h1FFF, full handshake → Data=32'hFFFFFFFF.
- Bounce: Set low for 3 edges, high for 1 edge, then low steadily → no Valid until 6 edges after the final low, with Data sampled at that edge.
- Held key: complete one input, keep Set low, raise Req again → Waiting=1 only after release plus 4 high samples. No second Valid until a new press.
- Abort and wrap: Req drops during DEB → IDLE, Contagem unchanged. After 256 completed inputs, Contagem=0.

Source files
------------

// File: rtl/controlador_entrada.sv
// rtl/controlador_entrada.sv - Set-key responder: debounces the key, latches the switches, four-phase handshake to the I/O module
// Optional build macro: SIGNED_INPUT_EN (sign-extends the 13 switch bits into Data)

module controlador_entrada #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [12:0] Switches,
  input  logic        Set,
  input  logic        Req,
  output logic [31:0] Data,
  output logic        Valid,
  output logic        Waiting,
  output logic [7:0]  Contagem
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    DEB,
    DELIVER,
    WAIT_RELEASE
  } state_t;

  // Terminal value of the stability counter; cnt never passes it, so it never wraps
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        sync1;
  logic        sync2;
  logic        pressed;
  logic [31:0] switch_word;

  // Two-flop synchronizer for the asynchronous key; resets to "released"
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= Set;
      sync2 <= sync1;
    end
  end

  // The key is active-low
  assign pressed = ~sync2;

  // Widen the 13 switch bits to the 32-bit word returned to the core
  always_comb begin
    switch_word = 32'd0;
`ifdef SIGNED_INPUT_EN
    switch_word = {{19{Switches[12]}}, Switches};
`else
    switch_word = {19'd0, Switches};
`endif
  end

  // Request/press/debounce/deliver/release sequencer with registered outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      Data     <= 32'd0;
      Valid    <= 1'b0;
      Waiting  <= 1'b0;
      Contagem <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          Valid   <= 1'b0;
          Waiting <= 1'b0;
          if (Req) begin
            state   <= WAIT_PRESS;
            Waiting <= 1'b1;
          end
        end

        WAIT_PRESS: begin
          if (!Req) begin
            state   <= IDLE;
            Waiting <= 1'b0;
          end else if (pressed) begin
            cnt   <= 8'd0;
            state <= DEB;
          end
        end

        DEB: begin
          // A dropped request outranks a debounce that would complete this cycle
          if (!Req) begin
            state   <= IDLE;
            Waiting <= 1'b0;
          end else if (!pressed) begin
            state <= WAIT_PRESS;
          end else if (cnt == CNT_MAX) begin
            Data     <= switch_word;
            Contagem <= Contagem + 8'd1;
            Valid    <= 1'b1;
            Waiting  <= 1'b0;
            state    <= DELIVER;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        DELIVER: begin
          if (!Req) begin
            cnt   <= 8'd0;
            Valid <= 1'b0;
            state <= WAIT_RELEASE;
          end
        end

        WAIT_RELEASE: begin
          // The key must be seen released for a full debounce window before
          // another request is served, so one press answers one request
          if (pressed) begin
            cnt <= 8'd0;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state   <= IDLE;
          Valid   <= 1'b0;
          Waiting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_entrada.sv
// tb/tb_controlador_entrada.sv - Randomized self-checking bench for controlador_entrada against a transaction-level model

module tb_controlador_entrada;

  localparam int D = 4;

  logic        Clock;
  logic        Reset;
  logic [12:0] Switches;
  logic        Set;
  logic        Req;
  logic [31:0] Data;
  logic        Valid;
  logic        Waiting;
  logic [7:0]  Contagem;

  int tests;
  int fails;

  // Reference model state: number of completed inputs and last delivered word
  int          model_count;
  logic [31:0] model_data;

  controlador_entrada #(.DEBOUNCE_CYCLES(D)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Switches (Switches),
    .Set      (Set),
    .Req      (Req),
    .Data     (Data),
    .Valid    (Valid),
    .Waiting  (Waiting),
    .Contagem (Contagem)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] widen(input logic [12:0] sw);
`ifdef SIGNED_INPUT_EN
    return 32'($signed(sw));
`else
    return 32'(sw);
`endif
  endfunction

  // One complete input transaction. Optional bounce of g low / h high edges
  // before the steady press; hold_req keeps a new request pending during release.
  task automatic serve(input logic [12:0] sw, input int g, input int h, input bit hold_req);
    int hold;
    Req = 1'b1;
    @(negedge Clock);
    check("waiting_after_req", 32'(Waiting), 32'd1);
    check("valid_before_press", 32'(Valid), 32'd0);
    if (g > 0) begin
      Set = 1'b0;
      repeat (g) begin
        @(negedge Clock);
        check("valid_during_bounce", 32'(Valid), 32'd0);
      end
      Set = 1'b1;
      repeat (h) begin
        @(negedge Clock);
        check("valid_during_bounce", 32'(Valid), 32'd0);
      end
    end
    Set = 1'b0;
    for (int k = 0; k <= D + 2; k++) begin
      Switches = (k == D + 2) ? sw : 13'($urandom);
      @(negedge Clock);
      if (k < D + 2) begin
        check("valid_during_debounce", 32'(Valid), 32'd0);
        check("waiting_during_debounce", 32'(Waiting), 32'd1);
      end else begin
        model_count++;
        model_data = widen(sw);
        check("valid_at_latch_edge", 32'(Valid), 32'd1);
        check("waiting_at_latch_edge", 32'(Waiting), 32'd0);
        check("data_latched", Data, model_data);
        check("contagem_after_input", 32'(Contagem), 32'(model_count % 256));
      end
    end
    hold = $urandom_range(1, 3);
    repeat (hold) begin
      Switches = 13'($urandom);
      @(negedge Clock);
      check("valid_held", 32'(Valid), 32'd1);
      check("data_held", Data, model_data);
    end
    Req = 1'b0;
    @(negedge Clock);
    check("valid_drop", 32'(Valid), 32'd0);
    check("data_after_drop", Data, model_data);
    Req = hold_req;
    hold = $urandom_range(0, 3);
    repeat (hold) begin
      @(negedge Clock);
      check("held_key_no_waiting", 32'(Waiting), 32'd0);
      check("held_key_no_valid", 32'(Valid), 32'd0);
    end
    Set = 1'b1;
    for (int k = 0; k <= D + 2; k++) begin
      @(negedge Clock);
      check("release_waiting", 32'(Waiting), 32'(hold_req && (k == D + 2)));
      check("release_valid", 32'(Valid), 32'd0);
    end
    if (hold_req) begin
      Req = 1'b0;
      @(negedge Clock);
      check("waiting_withdrawn", 32'(Waiting), 32'd0);
    end
  endtask

  // Request withdrawn while the press is being debounced; the edge at which
  // the withdrawal is seen may be the one that would have completed it.
  task automatic abort_input(input int j);
    Req = 1'b1;
    @(negedge Clock);
    check("abort_waiting", 32'(Waiting), 32'd1);
    Set = 1'b0;
    for (int k = 0; k < j; k++) begin
      Switches = 13'($urandom);
      @(negedge Clock);
      check("abort_no_valid", 32'(Valid), 32'd0);
    end
    Req = 1'b0;
    @(negedge Clock);
    check("abort_waiting_off", 32'(Waiting), 32'd0);
    check("abort_valid", 32'(Valid), 32'd0);
    check("abort_contagem", 32'(Contagem), 32'(model_count % 256));
    check("abort_data", Data, model_data);
    Set = 1'b1;
    repeat (3) @(negedge Clock);
    check("abort_settled_valid", 32'(Valid), 32'd0);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    model_count = 0;
    model_data  = 32'd0;
    Reset    = 1'b0;
    Set      = 1'b1;
    Req      = 1'b0;
    Switches = 13'd0;
    #1;
    check("reset_data", Data, 32'd0);
    check("reset_valid", 32'(Valid), 32'd0);
    check("reset_waiting", 32'(Waiting), 32'd0);
    check("reset_contagem", 32'(Contagem), 32'd0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("idle_waiting", 32'(Waiting), 32'd0);

    serve(13'h0ABC, 0, 0, 1'b0);
    serve(13'h1FFF, 0, 0, 1'b0);
    serve(13'h1000, 3, 1, 1'b0);
    serve(13'h0123, 0, 0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      int g;
      g = ($urandom_range(0, 1) == 1) ? $urandom_range(1, D) : 0;
      serve(13'($urandom), g, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    abort_input(D + 2);
    abort_input(3);
    for (int i = 0; i < 4; i++) abort_input($urandom_range(3, D + 2));

    // Asynchronous reset while debouncing, then re-serve the pending request
    Req = 1'b1;
    @(negedge Clock);
    Set = 1'b0;
    repeat (4) @(negedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    check("midreset_data", Data, 32'd0);
    check("midreset_valid", 32'(Valid), 32'd0);
    check("midreset_waiting", 32'(Waiting), 32'd0);
    check("midreset_contagem", 32'(Contagem), 32'd0);
    model_count = 0;
    model_data  = 32'd0;
    Set = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("reserve_waiting", 32'(Waiting), 32'd1);
    Req = 1'b0;
    @(negedge Clock);
    check("reserve_withdrawn", 32'(Waiting), 32'd0);

    // Counter wrap: 255 then 256 completed inputs since reset
    for (int i = 0; i < 255; i++) serve(13'($urandom), 0, 0, 1'b0);
    check("contagem_255", 32'(Contagem), 32'd255);
    serve(13'($urandom), 0, 0, 1'b0);
    check("contagem_wrap", 32'(Contagem), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
